// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides and a registered result.
// Define ALU_EXEC_BARREL_EN for single-cycle barrel shifts; otherwise shifts iterate 1 bit per cycle.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControlE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResultE,
    output logic             ZeroE,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

`ifdef ALU_EXEC_BARREL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic [WIDTH-1:0] alu_value;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             accept;

    assign shamt      = SrcBE[SHW-1:0];
    assign is_shift   = (ALUControlE == 3'b100) || (ALUControlE[2:1] == 2'b11);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_reg == HOLD);
    assign ALUResultE = result_reg;
    assign ZeroE      = zero_reg;

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Single-cycle result; shift codes fall through to SrcAE, which is the shamt=0 answer.
    always_comb begin
        alu_value = SrcAE;
        case (ALUControlE)
            3'b000: alu_value = SrcAE + SrcBE;
            3'b001: alu_value = SrcAE - SrcBE;
            3'b010: alu_value = SrcAE & SrcBE;
            3'b011: alu_value = SrcAE | SrcBE;
            3'b101: alu_value = {{(WIDTH-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
`ifdef ALU_EXEC_BARREL_EN
            3'b100: alu_value = SrcAE << shamt;
            3'b110: alu_value = SrcAE >> shamt;
            3'b111: alu_value = $signed(SrcAE) >>> shamt;
`endif
            default: alu_value = SrcAE;
        endcase
    end

`ifdef ALU_EXEC_BARREL_EN
    assign busy = 1'b0;
`else
    logic [WIDTH-1:0] acc_reg, acc_next, acc_step;
    logic [SHW-1:0]   count_reg, count_next;
    logic [1:0]       op_reg, op_next;

    assign busy = (state_reg == SHIFT);

    // op_reg keeps ALUControlE[1:0]: 00 sll, 10 srl, 11 sra.
    always_comb begin
        acc_step = acc_reg;
        case (op_reg)
            2'b00:   acc_step = {acc_reg[WIDTH-2:0], 1'b0};
            2'b10:   acc_step = {1'b0, acc_reg[WIDTH-1:1]};
            default: acc_step = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
        endcase
    end
`endif

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
`ifndef ALU_EXEC_BARREL_EN
        acc_next    = acc_reg;
        count_next  = count_reg;
        op_next     = op_reg;
`endif
        case (state_reg)
            HOLD: if (out_ready) state_next = IDLE;
`ifndef ALU_EXEC_BARREL_EN
            SHIFT: begin
                acc_next   = acc_step;
                count_next = count_reg - SHW'(1);
                if (count_reg == SHW'(1)) begin
                    state_next  = HOLD;
                    result_next = acc_step;
                    zero_next   = (acc_step == '0);
                end
            end
`endif
            default: ;
        endcase
        // Acceptance from HOLD overrides the return to IDLE (back-to-back).
        if (accept) begin
`ifndef ALU_EXEC_BARREL_EN
            if (is_shift && (shamt != '0)) begin
                state_next = SHIFT;
                acc_next   = SrcAE;
                count_next = shamt;
                op_next    = ALUControlE[1:0];
            end else
`endif
            begin
                state_next  = HOLD;
                result_next = alu_value;
                zero_next   = (alu_value == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
`ifndef ALU_EXEC_BARREL_EN
            acc_reg    <= '0;
            count_reg  <= '0;
            op_reg     <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
`ifndef ALU_EXEC_BARREL_EN
            acc_reg    <= acc_next;
            count_reg  <= count_next;
            op_reg     <= op_next;
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: transaction-level model plus directed literal checks.
// Honours ALU_EXEC_BARREL_EN to expect single-cycle shifts.
module tb_alu_exec_unit;
`ifdef ALU_EXEC_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  ALUControlE = 3'b000;
    logic [31:0] SrcAE = 32'h0;
    logic [31:0] SrcBE = 32'h0;
    logic        in_ready, out_valid, ZeroE, busy;
    logic [31:0] ALUResultE;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControlE(ALUControlE), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResultE(ALUResultE),
        .ZeroE(ZeroE), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = int'(b[4:0]);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: return a << k;
            3'd6: return a >> k;
            default: return $signed(a) >>> k;
        endcase
    endfunction

    function automatic bit is_shift_op(input logic [2:0] c);
        return (c == 3'd4) || (c == 3'd6) || (c == 3'd7);
    endfunction

    // Model: a held result, or a result pending for m_wait more edges.
    logic        m_hold = 1'b0;
    logic        m_zero = 1'b0;
    logic [31:0] m_res = 32'h0;
    logic [31:0] m_pend = 32'h0;
    int          m_wait = 0;
    logic        m_in_ready;
    assign m_in_ready = (m_wait == 0) && (!m_hold || out_ready);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hold <= 1'b0; m_zero <= 1'b0; m_res <= 32'h0; m_pend <= 32'h0; m_wait <= 0;
        end else begin
            if (m_hold && out_ready) m_hold <= 1'b0;
            if (m_wait > 0) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_hold <= 1'b1; m_res <= m_pend; m_zero <= (m_pend == 32'h0);
                end
            end
            if (in_valid && m_in_ready) begin
                if (is_shift_op(ALUControlE) && (SrcBE[4:0] != 5'd0) && !BARREL) begin
                    m_wait <= int'(SrcBE[4:0]);
                    m_pend <= model_op(ALUControlE, SrcAE, SrcBE);
                end else begin
                    m_hold <= 1'b1;
                    m_res  <= model_op(ALUControlE, SrcAE, SrcBE);
                    m_zero <= (model_op(ALUControlE, SrcAE, SrcBE) == 32'h0);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
        check("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready});
        check("busy", {31'b0, busy}, {31'b0, (m_wait > 0)});
        if (m_hold) begin
            check("result", ALUResultE, m_res);
            check("zero", {31'b0, ZeroE}, {31'b0, m_zero});
        end
    end

    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        ALUControlE = c; SrcAE = a; SrcBE = b; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk); #1;
        in_valid = 1'b0;
        $display("op=%0d a=%08h b=%08h accepted at %0t", c, a, b, $time);
    endtask

    task automatic wait_valid(output int cycles, output int busy_cycles);
        cycles = 0; busy_cycles = 0;
        while (!out_valid && cycles < 40) begin
            if (busy) busy_cycles++;
            cycles++;
            @(negedge clk);
        end
        if (!out_valid) check("result_timeout", 32'd0, 32'd1);
    endtask

    logic [2:0]  t_c [9] = '{3'd6, 3'd4, 3'd7, 3'd3, 3'd1, 3'd4, 3'd7, 3'd5, 3'd2};
    logic [31:0] t_a [9] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0F0F0000, 32'h0,
                             32'h1, 32'hFFFFFFFF, 32'h80000000, 32'hAAAAAAAA};
    logic [31:0] t_b [9] = '{32'd31, 32'd31, 32'd1, 32'h000000F0, 32'h1,
                             32'h21, 32'd31, 32'h7FFFFFFF, 32'h55555555};
    logic [31:0] t_e [9] = '{32'h1, 32'h80000000, 32'h3FFFFFFF, 32'h0F0F00F0, 32'hFFFFFFFF,
                             32'h2, 32'hFFFFFFFF, 32'h1, 32'h0};

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, bcyc;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", ALUResultE, 32'd0);
        check("rst_zero", {31'b0, ZeroE}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        #1;

        send(3'd0, 32'h7FFFFFFF, 32'h1);
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_result", ALUResultE, 32'h80000000);
        check("add_zero", {31'b0, ZeroE}, 32'd0);
        send(3'd1, 32'd5, 32'd5);
        check("sub_result", ALUResultE, 32'h0);
        check("sub_zero", {31'b0, ZeroE}, 32'd1);

        send(3'd5, 32'hFFFFFFFF, 32'h1);
        check("slt_neg", ALUResultE, 32'h1);
        send(3'd5, 32'h1, 32'hFFFFFFFF);
        check("slt_swap", ALUResultE, 32'h0);

        send(3'd7, 32'h80000000, 32'd4);
        wait_valid(cyc, bcyc);
        check("sra_latency", cyc, BARREL ? 32'd0 : 32'd4);
        check("sra_busy_cycles", bcyc, BARREL ? 32'd0 : 32'd4);
        check("sra_result", ALUResultE, 32'hF8000000);
        $display("sra latency=%0d busy=%0d result=%08h", cyc, bcyc, ALUResultE);
        @(negedge clk); #1;

        out_ready = 1'b0;
        send(3'd0, 32'd3, 32'd4);
        ALUControlE = 3'd2; SrcAE = 32'h0000F0F0; SrcBE = 32'h00000FF0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_result", ALUResultE, 32'd7);
            check("bp_zero", {31'b0, ZeroE}, 32'd0);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        in_valid = 1'b0;
        check("b2b_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_result", ALUResultE, 32'h000000F0);
        $display("back-to-back and result=%08h", ALUResultE);

        send(3'd4, 32'h1, 32'd20);
        repeat (5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk); #1 reset_n = 1'b1;
        send(3'd4, 32'h1, 32'd0);
        check("sll0_valid", {31'b0, out_valid}, 32'd1);
        check("sll0_result", ALUResultE, 32'h1);

        for (int i = 0; i < 9; i++) begin
            send(t_c[i], t_a[i], t_b[i]);
            wait_valid(cyc, bcyc);
            check("table_result", ALUResultE, t_e[i]);
            check("table_zero", {31'b0, ZeroE}, {31'b0, (t_e[i] == 32'h0)});
            #1;
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 3-bit ALU control code produced by the ALU decoder.
- Performs the operation with a valid/ready handshake on both sides.
- Holds the result in an output register until it is taken.
- add/sub/and/or/slt complete in one cycle; the otherwise-unused codes 100/110/111 implement sll/srl/sra with an iterative 1-bit-per-cycle shifter, unless the barrel option is compiled in.

Parameters:
- WIDTH, 32, datapath width in bits; shift amount width is $clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and control valid
- in_ready  out  1  unit can accept an operation this cycle
- ALUControlE  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 100 sll, 110 srl, 111 sra
- SrcAE  in  WIDTH  operand A (shift source)
- SrcBE  in  WIDTH  operand B; for shifts only bits [$clog2(WIDTH)-1:0] are used (shamt)
- out_valid  out  1  ALUResultE/ZeroE valid
- out_ready  in  1  downstream accepts the result
- ALUResultE  out  WIDTH  registered result
- ZeroE  out  1  registered (ALUResultE == 0)
- busy  out  1  high while iterative shift in progress

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - out_valid=0, ALUResultE=0, ZeroE=0, busy=0.
  - Shift counter and accumulator cleared.
  - Reset mid-shift abandons the operation; no result is produced.
- Acceptance: in_valid && in_ready at edge N.
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, busy=1.
  - HOLD: out_valid=1; in_ready=out_ready.
- Transitions:
  - IDLE, accept non-shift -> result computed combinationally from the inputs and registered at edge N; HOLD after edge N.
  - IDLE, accept shift with shamt=0 -> ALUResultE=SrcAE; HOLD after edge N.
  - IDLE, accept shift with shamt=k>0 -> accumulator=SrcAE, count=k; SHIFT after edge N.
  - SHIFT: each edge shifts the accumulator 1 bit and decrements count. sll fills with 0, srl fills with 0, sra replicates the MSB. On the edge where count reaches 0, the result is registered and the state moves to HOLD. out_valid therefore rises after edge N+k.
  - HOLD, out_ready=0 -> stay. ALUResultE and ZeroE must not change.
  - HOLD, out_ready=1, in_valid=0 -> IDLE. out_valid=0 after the edge.
  - HOLD, out_ready=1, in_valid=1 -> back-to-back: the new operation is accepted on the same edge the old result is consumed. Next state follows the IDLE accept rules.
- Arithmetic:
  - add/sub are modulo 2^WIDTH; carry and overflow are discarded.
  - slt is signed two's-complement: result = {WIDTH-1 zeros, (SrcAE < SrcBE signed)}.
  - and/or are bitwise.
- ZeroE is always registered together with ALUResultE from the same value.
- in_valid while in_ready=0 is ignored. Upstream must hold its inputs; the unit does not latch them.
- Inputs are sampled only at the accept edge. Changes to SrcAE/SrcBE/ALUControlE during SHIFT have no effect.
- busy equals (state==SHIFT).
- Maximum shift latency is WIDTH-1 edges (shamt=WIDTH-1).

Optional Feature:
- Macro: ALU_EXEC_BARREL_EN.
- Defined:
  - Shifts use a single-cycle barrel shifter and behave exactly like non-shift ops: HOLD after the accept edge for any shamt.
  - The SHIFT state, counter and accumulator are not built; busy is tied 0.
- Undefined: iterative shifter as described in Behaviour.
- Results must be bit-identical in both builds; only latency differs.

Test Plan:
- Reset then idle -> out_valid=0, ALUResultE=0, ZeroE=0, in_ready=1, busy=0.
- Accept add 0x7FFFFFFF+0x1, out_ready=1 -> next cycle out_valid=1, ALUResultE=0x80000000, ZeroE=0. Then accept sub 5-5 -> ALUResultE=0, ZeroE=1.
- slt with SrcAE=0xFFFFFFFF (-1), SrcBE=1 -> ALUResultE=1. Swap the operands -> ALUResultE=0.
- sra SrcAE=0x80000000, shamt=4, accepted at edge N:
  - busy=1 for 4 cycles.
  - out_valid rises after edge N+4 with ALUResultE=0xF8000000.
  - With ALU_EXEC_BARREL_EN defined: out_valid after edge N with the same value.
- Backpressure: result held with out_ready=0 for 3 cycles -> ALUResultE/ZeroE stable, in_ready=0. Then out_ready=1 with a new and 0xF0F0&0x0FF0 pending -> consumed and accepted on the same edge; next result 0x00F0.
- Assert reset_n=0 mid-shift (sll, shamt=20, after 5 cycles) -> out_valid=0, busy=0, state IDLE. After release, sll 1<<0 -> ALUResultE=1 one cycle after accept.
